// File: rtl/cr_huf_comp_sa_st_rd_pkg.sv
// Shared types and defaults for the symbol-assembler side reader of the Huffman symbol-table LUT.
package cr_huf_comp_sa_st_rd_pkg;

  localparam int SA_LUT_DEPTH = 288;
  localparam int SA_ADDR_W    = 9;
  localparam int SA_CODE_W    = 15;
  localparam int SA_LEN_W     = 4;

  typedef enum logic [2:0] {
    SA_IDLE,
    SA_PT,
    SA_WAIT,
    SA_RD,
    SA_DRAIN,
    SA_DONE
  } e_sa_rd_state;

  typedef struct packed {
    logic [SA_LEN_W-1:0]  len;
    logic [SA_CODE_W-1:0] code;
    logic [SA_ADDR_W-1:0] idx;
  } s_sa_sym;

endpackage

// File: rtl/cr_huf_comp_sa_skid.sv
// Two-entry valid/ready FIFO between the LUT read port and the packer; entry 0 is always the head.
module cr_huf_comp_sa_skid #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         vld,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0, e1;
  logic         do_pop;

  assign do_pop = pop & (count != 2'd0);
  assign vld    = (count != 2'd0);
  assign head   = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: if (push) begin
          e0    <= push_data;
          count <= 2'd1;
        end
        2'd1: begin
          if (push && do_pop) e0 <= push_data;
          else if (push) begin
            e1    <= push_data;
            count <= 2'd2;
          end else if (do_pop) count <= 2'd0;
        end
        default: if (do_pop) begin
          e0 <= e1;
          if (push) e1 <= push_data;
          else count <= 2'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_sa_st_rd.sv
// Consumer side of the ST FSM handshake: sweeps the symbol-table LUT and streams {len,code,idx} to the packer.
module cr_huf_comp_sa_st_rd
  import cr_huf_comp_sa_st_rd_pkg::*;
#(
  parameter int LUT_DEPTH = SA_LUT_DEPTH,
  parameter int ADDR_W    = SA_ADDR_W,
  parameter int CODE_W    = SA_CODE_W,
  parameter int LEN_W     = SA_LEN_W,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_rdy_to_sa,
  input  logic                    st_tbl_rdy_to_sa,
  input  logic                    st_pass_thru,
  input  logic                    sa_blk_eob,
  output logic                    lut_rd_en,
  output logic [ADDR_W-1:0]       lut_rd_addr,
  input  logic [LEN_W+CODE_W-1:0] lut_rd_data,
  output logic                    sym_vld,
  input  logic                    sym_rdy,
  output logic [LEN_W-1:0]        sym_len,
  output logic [CODE_W-1:0]       sym_code,
  output logic [ADDR_W-1:0]       sym_idx,
  output logic                    sa_st_read_done,
  output logic                    sa_busy,
  output logic                    sa_abort
);

  localparam int                DW   = LEN_W + CODE_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LUT_DEPTH - 1);

  e_sa_rd_state      state, state_nxt;
  logic [ADDR_W-1:0] addr, rd_idx_q;
  logic              inflight, abort, rd_en, push, pop, in_sweep;
  logic [1:0]        fifo_count;
  logic [2:0]        credit;
  logic [LEN_W-1:0]  rd_len;
  logic [DW-1:0]     head;

  assign rd_len   = lut_rd_data[LEN_W+CODE_W-1 -: LEN_W];
  assign in_sweep = (state == SA_WAIT) | (state == SA_RD) | (state == SA_DRAIN);
  assign abort    = in_sweep & ~st_rdy_to_sa & ~st_tbl_rdy_to_sa;
  assign pop      = sym_vld & sym_rdy;

  // Occupancy net of this cycle's pop, so a full-rate stream keeps issuing one read per cycle.
  assign credit = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight};
  assign rd_en  = (state == SA_RD) & ~abort & (credit < 3'd2);
  assign push   = inflight & ~abort & (!SKIP_ZERO || rd_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SA_IDLE;
      addr     <= '0;
      rd_idx_q <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (rd_en) rd_idx_q <= addr;
      if (state != SA_RD) addr <= '0;
      else if (rd_en && addr != LAST) addr <= addr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SA_IDLE:  if (st_rdy_to_sa) state_nxt = st_pass_thru ? SA_PT : SA_WAIT;
      SA_PT:    if (sa_blk_eob) state_nxt = SA_DONE;
      SA_WAIT:  if (abort) state_nxt = SA_IDLE;
                else if (st_tbl_rdy_to_sa) state_nxt = SA_RD;
      SA_RD:    if (abort) state_nxt = SA_IDLE;
                else if (rd_en && addr == LAST) state_nxt = SA_DRAIN;
      SA_DRAIN: if (abort) state_nxt = SA_IDLE;
                else if (!inflight && fifo_count == 2'd0) state_nxt = SA_DONE;
      SA_DONE:  state_nxt = SA_IDLE;
      default:  state_nxt = SA_IDLE;
    endcase
  end

  cr_huf_comp_sa_skid #(.W(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data ({lut_rd_data, rd_idx_q}),
    .pop       (pop),
    .vld       (sym_vld),
    .head      (head),
    .count     (fifo_count)
  );

  assign {sym_len, sym_code, sym_idx} = head;
  assign lut_rd_en       = rd_en;
  assign lut_rd_addr     = addr;
  assign sa_st_read_done = (state == SA_DONE);
  assign sa_busy         = (state != SA_IDLE);
  assign sa_abort        = abort;

endmodule

// File: tb/tb_cr_huf_comp_sa_st_rd.sv
// Randomized scoreboard bench: LUT model, expected-symbol queue, monitor comparing every transfer.
module tb_cr_huf_comp_sa_st_rd;
  import cr_huf_comp_sa_st_rd_pkg::*;

  localparam int DW = SA_LEN_W + SA_CODE_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic st_rdy_to_sa = 1'b0, st_tbl_rdy_to_sa = 1'b0, st_pass_thru = 1'b0, sa_blk_eob = 1'b0;
  logic sym_rdy = 1'b0;

  logic                 lut_rd_en, sym_vld, done, busy, abort;
  logic [SA_ADDR_W-1:0] lut_rd_addr, sym_idx;
  logic [DW-1:0]        lut_rd_data = '0;
  logic [SA_LEN_W-1:0]  sym_len;
  logic [SA_CODE_W-1:0] sym_code;

  logic                 lut_rd_en0, sym_vld0, done0, busy0, abort0;
  logic [SA_ADDR_W-1:0] lut_rd_addr0, sym_idx0;
  logic [DW-1:0]        lut_rd_data0 = '0;
  logic [SA_LEN_W-1:0]  sym_len0;
  logic [SA_CODE_W-1:0] sym_code0;

  always #5 clk = ~clk;

  cr_huf_comp_sa_st_rd u_dut (
    .clk(clk), .rst_n(rst_n), .st_rdy_to_sa(st_rdy_to_sa), .st_tbl_rdy_to_sa(st_tbl_rdy_to_sa),
    .st_pass_thru(st_pass_thru), .sa_blk_eob(sa_blk_eob), .lut_rd_en(lut_rd_en),
    .lut_rd_addr(lut_rd_addr), .lut_rd_data(lut_rd_data), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .sym_len(sym_len), .sym_code(sym_code), .sym_idx(sym_idx), .sa_st_read_done(done),
    .sa_busy(busy), .sa_abort(abort));

  cr_huf_comp_sa_st_rd #(.SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .st_rdy_to_sa(st_rdy_to_sa), .st_tbl_rdy_to_sa(st_tbl_rdy_to_sa),
    .st_pass_thru(st_pass_thru), .sa_blk_eob(sa_blk_eob), .lut_rd_en(lut_rd_en0),
    .lut_rd_addr(lut_rd_addr0), .lut_rd_data(lut_rd_data0), .sym_vld(sym_vld0), .sym_rdy(sym_rdy),
    .sym_len(sym_len0), .sym_code(sym_code0), .sym_idx(sym_idx0), .sa_st_read_done(done0),
    .sa_busy(busy0), .sa_abort(abort0));

  // LUT model: data valid only the cycle after a read, garbage otherwise.
  logic [DW-1:0] lut [SA_LUT_DEPTH];
  always @(posedge clk) begin
    lut_rd_data  <= lut_rd_en  ? lut[lut_rd_addr]  : DW'($urandom);
    lut_rd_data0 <= lut_rd_en0 ? lut[lut_rd_addr0] : DW'($urandom);
  end

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, done_cnt0 = 0, abort_cnt = 0, abort_cnt0 = 0, rd_cnt = 0, vld_cnt = 0;
  int idx0_next = 0, rdy_pct = 100;
  s_sa_sym exp_q[$];
  s_sa_sym prev_sym;
  logic    prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1 sym_rdy = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_vld", {31'b0, sym_vld}, 32'd1);
        chk("stall_data", {4'b0, sym_len, sym_code, sym_idx}, {4'b0, prev_sym});
      end
      if (sym_vld && sym_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sym_extra: got idx %0d expected no symbol", sym_idx);
        end else begin
          s_sa_sym e;
          e = exp_q.pop_front();
          chk("sym", {4'b0, sym_len, sym_code, sym_idx}, {4'b0, e});
        end
      end
      if (sym_vld0 && sym_rdy) begin
        chk("sym0_idx", {23'b0, sym_idx0}, idx0_next);
        chk("sym0_data", {13'b0, sym_len0, sym_code0}, {13'b0, lut[sym_idx0]});
        idx0_next++;
      end
      if (lut_rd_en && lut_rd_addr >= SA_ADDR_W'(SA_LUT_DEPTH)) begin
        n_chk++; n_fail++;
        $display("FAIL rd_range: got addr %0d expected < %0d", lut_rd_addr, SA_LUT_DEPTH);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_pop", exp_q.size(), 0);
      end
      prev_stall = sym_vld & ~sym_rdy & ~abort;
      prev_sym   = '{len: sym_len, code: sym_code, idx: sym_idx};
      if (done0)     done_cnt0++;
      if (abort)     abort_cnt++;
      if (abort0)    abort_cnt0++;
      if (lut_rd_en) rd_cnt++;
      if (sym_vld)   vld_cnt++;
    end
  end

  task automatic fill(input int mode);
    for (int i = 0; i < SA_LUT_DEPTH; i++)
      case (mode)
        0:       lut[i] = {SA_LEN_W'(i % 16), SA_CODE_W'(i)};
        1:       lut[i] = '0;
        default: lut[i] = ($urandom_range(3) == 0) ? {SA_LEN_W'(0), SA_CODE_W'($urandom)} : DW'($urandom);
      endcase
  endtask

  // Expected stream: every non-zero-length entry in ascending index order.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < SA_LUT_DEPTH; i++)
      if (lut[i][DW-1 -: SA_LEN_W] != '0)
        exp_q.push_back('{len: lut[i][DW-1 -: SA_LEN_W], code: lut[i][SA_CODE_W-1:0],
                          idx: SA_ADDR_W'(i)});
  endtask

  task automatic clr_cnt();
    done_cnt = 0; done_cnt0 = 0; abort_cnt = 0; abort_cnt0 = 0;
    rd_cnt = 0; vld_cnt = 0; idx0_next = 0;
  endtask

  task automatic start_table();
    @(posedge clk);
    #1 st_rdy_to_sa = 1'b1; st_pass_thru = 1'b0;
    repeat (2) @(posedge clk);
    #1 st_rdy_to_sa = 1'b0; st_tbl_rdy_to_sa = 1'b1;
  endtask

  task automatic sweep(input int mode, input int pct, input string nm);
    int t, nexp;
    fill(mode);
    build_exp();
    nexp = exp_q.size();
    rdy_pct = pct;
    clr_cnt();
    start_table();
    t = 0;
    while ((done_cnt == 0 || done_cnt0 == 0) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1 st_tbl_rdy_to_sa = 1'b0;
    if (t >= 20000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, t);
    end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_done0"}, done_cnt0, 1);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_reads"}, rd_cnt, SA_LUT_DEPTH);
    chk({nm, "_n0"}, idx0_next, SA_LUT_DEPTH);
    if (nexp == 0) chk({nm, "_novld"}, vld_cnt, 0);
    chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t, done_c;
    #2;
    chk("rst_outs", {26'b0, lut_rd_en, sym_vld, done, busy, abort, lut_rd_en0}, 32'd0);
    chk("rst_sym", {4'b0, sym_len, sym_code, sym_idx}, 32'd0);
    chk("rst_addr", {23'b0, lut_rd_addr}, 32'd0);
    chk("rst_busy0", {31'b0, busy0}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through block: no reads, one done after eob.
    clr_cnt();
    exp_q.delete();
    @(posedge clk);
    #1 st_rdy_to_sa = 1'b1; st_pass_thru = 1'b1;
    done_c = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1 sa_blk_eob = (c == 10);
      if (done) begin
        done_c = c;
        st_rdy_to_sa = 1'b0; st_pass_thru = 1'b0;
      end
    end
    chk("pt_done_cycle", {31'b0, (done_c == 11 || done_c == 12)}, 32'd1);
    chk("pt_done_cnt", done_cnt, 1);
    chk("pt_reads", rd_cnt, 0);
    #1 sa_blk_eob = 1'b1;
    @(posedge clk);
    #1 sa_blk_eob = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("eob_idle_ignored", done_cnt, 1);

    sweep(0, 100, "ramp");
    sweep(1, 100, "zero");
    sweep(0, 30, "bp30");
    sweep(2, 60, "rnd");

    // Abort near read 100, then the next table must start from index 0.
    fill(2);
    build_exp();
    rdy_pct = 70;
    clr_cnt();
    start_table();
    t = 0;
    while (!(lut_rd_en && lut_rd_addr == SA_ADDR_W'(100)) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached", {31'b0, (t < 2000)}, 32'd1);
    @(posedge clk);
    #1 st_tbl_rdy_to_sa = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_cnt", abort_cnt, 1);
    chk("abort_cnt0", abort_cnt0, 1);
    chk("abort_no_done", done_cnt + done_cnt0, 0);
    chk("abort_idle", {30'b0, busy, sym_vld}, 32'd0);
    exp_q.delete();
    sweep(2, 80, "post_abort");

    // Reset while a symbol is stalled on the output.
    fill(0);
    build_exp();
    rdy_pct = 0;
    start_table();
    t = 0;
    while (!sym_vld && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_vld", {31'b0, sym_vld}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {27'b0, lut_rd_en, sym_vld, done, busy, abort}, 32'd0);
    chk("rst_mid_sym", {4'b0, sym_len, sym_code, sym_idx}, 32'd0);
    st_tbl_rdy_to_sa = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sweep(2, 50, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
